// File: rtl/dma_copy.sv
// -----------------------------------------------------------------------------
// dma_copy
//
// Single-channel word copy engine. It moves len 32-bit words from src to dst
// through one shared memory port. Each word is one granted read followed by
// one granted write, in ascending address order.
//
// Ports
//   clk     : system clock, rising-edge
//   reset   : asynchronous, active-low reset
//   start   : copy request, only looked at while idle
//   src     : byte address of first source word (must be word aligned)
//   dst     : byte address of first destination word (must be word aligned)
//   len     : number of words to copy
//   grant   : memory port granted to this block in the current cycle
//   busy    : copy in progress
//   done    : one-cycle pulse after a copy completes (or a len==0 request)
//   error   : one-cycle pulse after a misaligned request is rejected
//   count   : words written so far in the current / most recent copy
//   mem_a   : word-aligned byte address to memory
//   mem_we  : memory write enable
//   mem_wd  : memory write data
//   mem_rd  : memory read data, combinational for the current mem_a
// -----------------------------------------------------------------------------
module dma_copy #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src,
  input  logic [31:0]      dst,
  input  logic [LEN_W-1:0] len,
  input  logic             grant,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] count,
  output logic [31:0]      mem_a,
  output logic             mem_we,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0]       state_reg,     state_next;
  logic [31:0]      src_reg,       src_next;
  logic [31:0]      dst_reg,       dst_next;
  logic [LEN_W-1:0] remaining_reg, remaining_next;
  logic [LEN_W-1:0] count_reg,     count_next;
  logic [31:0]      data_reg,      data_next;
  logic             done_reg,      done_next;
  logic             error_reg,     error_next;

  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    remaining_next = remaining_reg;
    count_next     = count_reg;
    data_next      = data_reg;
    done_next      = 1'b0;
    error_next     = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if ((src[1:0] != 2'b00) || (dst[1:0] != 2'b00)) begin
            // Rejected request leaves count showing the previous copy.
            error_next = 1'b1;
          end else if (len == '0) begin
            // Empty copy completes without touching memory.
            done_next  = 1'b1;
            count_next = '0;
          end else begin
            src_next       = src;
            dst_next       = dst;
            remaining_next = len;
            count_next     = '0;
            state_next     = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (grant) begin
          data_next  = mem_rd;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (grant) begin
          // 32-bit wrap of the pointers is intentional and not flagged.
          src_next       = src_reg + 32'd4;
          dst_next       = dst_reg + 32'd4;
          count_next     = count_reg + LEN_W'(1);
          remaining_next = remaining_reg - LEN_W'(1);
          if (remaining_reg == LEN_W'(1)) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = ST_READ;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      remaining_reg <= '0;
      count_reg     <= '0;
      data_reg      <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      remaining_reg <= remaining_next;
      count_reg     <= count_next;
      data_reg      <= data_next;
      done_reg      <= done_next;
      error_reg     <= error_next;
    end
  end

  // Memory-side outputs decode only from the state register, so an
  // asynchronous reset forces mem_we low immediately, without a clock edge.
  always_comb begin
    mem_a  = 32'd0;
    mem_wd = 32'd0;
    mem_we = 1'b0;
    case (state_reg)
      ST_READ: begin
        mem_a = src_reg;
      end
      ST_WRITE: begin
        mem_a  = dst_reg;
        mem_wd = data_reg;
        mem_we = grant;
      end
      default: begin
        mem_a = 32'd0;
      end
    endcase
  end

  assign busy  = (state_reg == ST_READ) || (state_reg == ST_WRITE);
  assign done  = done_reg;
  assign error = error_reg;
  assign count = count_reg;

endmodule

// File: tb/tb_dma_copy.sv
// -----------------------------------------------------------------------------
// tb_dma_copy
//
// Directed bench for dma_copy. A small word memory answers the DUT's port.
// A word-level reference model (each word = one granted read then one granted
// write) predicts every output each cycle. Hand-computed literals pin the
// resulting memory contents, busy lengths and pulse counts.
// -----------------------------------------------------------------------------
module tb_dma_copy;

  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [31:0]      src = '0;
  logic [31:0]      dst = '0;
  logic [LEN_W-1:0] len = '0;
  logic             grant = 1'b0;
  logic             busy;
  logic             done;
  logic             error;
  logic [LEN_W-1:0] count;
  logic [31:0]      mem_a;
  logic             mem_we;
  logic [31:0]      mem_wd;
  logic [31:0]      mem_rd;

  int checks = 0;
  int passed = 0;

  dma_copy #(.LEN_W(LEN_W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .grant  (grant),
    .busy   (busy),
    .done   (done),
    .error  (error),
    .count  (count),
    .mem_a  (mem_a),
    .mem_we (mem_we),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
  );

  always #5 clk = ~clk;

  // Word memory indexed by address bits [9:2]; test addresses never alias.
  logic [31:0] ram [0:255] = '{default: 32'd0};
  logic        ld_en = 1'b0;
  logic [7:0]  ld_idx = '0;
  logic [31:0] ld_data = '0;

  assign mem_rd = ram[mem_a[9:2]];

  always @(posedge clk) begin
    if (ld_en)       ram[ld_idx] <= ld_data;
    else if (mem_we) ram[mem_a[9:2]] <= mem_wd;
  end

  // ---------------- reference model ----------------
  logic [31:0] mmem [0:255] = '{default: 32'd0};
  bit          m_active = 0;
  bit          m_wr     = 0;   // 0: current word still to be read, 1: to be written
  logic [31:0] m_src = '0, m_dst = '0, m_data = '0;
  int          m_left = 0;
  int          m_count = 0;
  bit          m_done = 0, m_err = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_wr = 0; m_src = '0; m_dst = '0; m_data = '0;
      m_left = 0; m_count = 0; m_done = 0; m_err = 0;
    end else begin
      if (ld_en) mmem[ld_idx] = ld_data;
      m_done = 0;
      m_err  = 0;
      if (!m_active) begin
        if (start) begin
          if (src[1:0] != 0 || dst[1:0] != 0) m_err = 1;
          else if (len == 0) begin m_done = 1; m_count = 0; end
          else begin
            m_active = 1; m_wr = 0; m_src = src; m_dst = dst;
            m_left = int'(len); m_count = 0;
          end
        end
      end else if (grant) begin
        if (!m_wr) begin
          m_data = mmem[m_src[9:2]];
          m_wr = 1;
        end else begin
          mmem[m_dst[9:2]] = m_data;
          m_src = m_src + 32'd4;
          m_dst = m_dst + 32'd4;
          m_count = m_count + 1;
          m_left = m_left - 1;
          m_wr = 0;
          if (m_left == 0) begin m_active = 0; m_done = 1; end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare of every DUT output against the model.
  always @(negedge clk) begin
    check("busy",   {31'd0, busy},   {31'd0, m_active});
    check("done",   {31'd0, done},   {31'd0, m_done});
    check("error",  {31'd0, error},  {31'd0, m_err});
    check("count",  {16'd0, count},  32'(m_count));
    check("mem_a",  mem_a,  m_active ? (m_wr ? m_dst : m_src) : 32'd0);
    check("mem_we", {31'd0, mem_we}, {31'd0, m_active && m_wr && grant});
    check("mem_wd", mem_wd, (m_active && m_wr) ? m_data : 32'd0);
  end

  task automatic preload(input logic [7:0] idx, input logic [31:0] data);
    ld_en = 1'b1; ld_idx = idx; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  // Issues one start, then runs a fixed window of cycles.
  // gmode 0: grant always high; gmode 1: grant 1,0,1,0,... from first cycle.
  // restart_at >= 0: re-assert start with different operands in that cycle.
  task automatic do_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                         input int gmode, input int restart_at,
                         output int busy_cyc, output int done_cnt,
                         output int err_cnt, output int we_cnt);
    int win;
    busy_cyc = 0; done_cnt = 0; err_cnt = 0; we_cnt = 0;
    win = 4 * n + 6;
    start = 1'b1; src = s; dst = d; len = LEN_W'(n);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < win; c++) begin
      grant = (gmode == 0) ? 1'b1 : ((c % 2) == 0);
      if (c == restart_at) begin
        start = 1'b1; src = 32'h0000_0140; dst = 32'h0000_02C0; len = 16'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy)   busy_cyc++;
      if (done)   done_cnt++;
      if (error)  err_cnt++;
      if (mem_we) we_cnt++;
      @(posedge clk); #1;
    end
    grant = 1'b0; start = 1'b0;
    $display("copy src=%08h dst=%08h len=%0d gmode=%0d busy=%0d done=%0d err=%0d writes=%0d",
             s, d, n, gmode, busy_cyc, done_cnt, err_cnt, we_cnt);
  endtask

  localparam logic [31:0] WA = 32'hAAAA_0001, WB = 32'hBBBB_0002, WC = 32'hCCCC_0003;
  localparam logic [31:0] WD = 32'hDDDD_0004, WE = 32'hEEEE_0005, WF = 32'hFFFF_0006;
  localparam logic [31:0] WG = 32'h1111_0007, WX = 32'h5A5A_1234;

  initial begin
    int bc, dc, ec, wc, dn;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy},   32'd0);
    check("rst_count",  {16'd0, count},  32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_a",  mem_a,           32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    preload(8'd64, WA); preload(8'd65, WB); preload(8'd66, WC);
    preload(8'd80, WD); preload(8'd81, WE); preload(8'd82, WF); preload(8'd83, WG);
    preload(8'd255, WX);

    // Basic 3-word copy, grant held high
    do_copy(32'h100, 32'h200, 3, 0, -1, bc, dc, ec, wc);
    check("c1_busy_cycles", 32'(bc), 32'd6);
    check("c1_done_pulses", 32'(dc), 32'd1);
    check("c1_writes",      32'(wc), 32'd3);
    check("c1_count",       {16'd0, count}, 32'd3);
    check("c1_ram0", ram[128], WA);
    check("c1_ram1", ram[129], WB);
    check("c1_ram2", ram[130], WC);

    // Same copy with toggling grant: 5 grant-low cycles while busy
    do_copy(32'h100, 32'h300, 3, 1, -1, bc, dc, ec, wc);
    check("c2_busy_cycles", 32'(bc), 32'd11);
    check("c2_done_pulses", 32'(dc), 32'd1);
    check("c2_writes",      32'(wc), 32'd3);
    check("c2_ram0", ram[192], WA);
    check("c2_ram1", ram[193], WB);
    check("c2_ram2", ram[194], WC);

    // Misaligned src, then misaligned dst
    do_copy(32'h102, 32'h400, 2, 0, -1, bc, dc, ec, wc);
    check("e1_err_pulses", 32'(ec), 32'd1);
    check("e1_busy",       32'(bc), 32'd0);
    check("e1_writes",     32'(wc), 32'd0);
    check("e1_done",       32'(dc), 32'd0);
    check("e1_count_kept", {16'd0, count}, 32'd3);
    do_copy(32'h100, 32'h201, 1, 0, -1, bc, dc, ec, wc);
    check("e2_err_pulses", 32'(ec), 32'd1);
    check("e2_writes",     32'(wc), 32'd0);

    // Zero-length request
    do_copy(32'h100, 32'h200, 0, 0, -1, bc, dc, ec, wc);
    check("z_done_pulses", 32'(dc), 32'd1);
    check("z_busy",        32'(bc), 32'd0);
    check("z_writes",      32'(wc), 32'd0);
    check("z_count",       {16'd0, count}, 32'd0);

    // Start re-asserted mid-copy is ignored
    do_copy(32'h100, 32'h280, 3, 0, 2, bc, dc, ec, wc);
    check("r_busy_cycles", 32'(bc), 32'd6);
    check("r_done_pulses", 32'(dc), 32'd1);
    check("r_err_pulses",  32'(ec), 32'd0);
    check("r_ram0", ram[160], WA);
    check("r_ram1", ram[161], WB);
    check("r_ram2", ram[162], WC);
    check("r_alt_untouched", ram[176], 32'd0);
    check("r_count", {16'd0, count}, 32'd3);

    // Reset during the write of word 2 of a 4-word copy
    start = 1'b1; src = 32'h140; dst = 32'h240; len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0; grant = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("ar_we_before", {31'd0, mem_we}, 32'd1);
    check("ar_a_before",  mem_a, 32'h244);
    #2 reset = 1'b0;
    #1;
    check("ar_we_now",    {31'd0, mem_we}, 32'd0);
    check("ar_busy_now",  {31'd0, busy},   32'd0);
    check("ar_count_now", {16'd0, count},  32'd0);
    check("ar_a_now",     mem_a,           32'd0);
    @(posedge clk); #1;
    reset = 1'b1; grant = 1'b0;
    check("ar_word1", ram[144], WD);
    check("ar_word2", ram[145], 32'd0);
    // Wrap-around copy issued on the first edge after release;
    // word 2 reads 0x0 after word 1 was written there.
    do_copy(32'hFFFF_FFFC, 32'h0, 2, 0, -1, bc, dc, ec, wc);
    check("w_busy_cycles", 32'(bc), 32'd4);
    check("w_done_pulses", 32'(dc), 32'd1);
    check("w_ram0", ram[0], WX);
    check("w_ram1", ram[1], WX);
    check("w_count", {16'd0, count}, 32'd2);
    check("ar_word2_after", ram[145], 32'd0);

    dn = 0;
    repeat (4) begin @(negedge clk); if (done) dn++; end
    check("quiet_done", 32'(dn), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
